// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO.
// Holds the hand-off FSM state encoding and the default byte width.
package uart_tx_fifo_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    // Hand-off FSM: pop in IDLE, pulse WRITES in LOAD, then wait for TXRDY
    // to fall (byte accepted) and rise again (transmitter free).
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_RDY  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous byte FIFO with separate occupancy count, flush and sticky overflow.
// Ports:
//   clk_i, rst_ni   - clock, synchronous active-low reset
//   wr_en_i/wr_data_i - push strobe and data; dropped (and overflow set) when full
//   rd_en_i         - pop strobe; rd_data_o shows the head entry combinationally
//   flush_i         - empty the FIFO on the next edge; overrides push and pop
//   ovf_clr_i       - clear sticky overflow (a same-cycle full push wins)
//   full_o, empty_o, count_o, overflow_o - registered status
module uart_tx_fifo_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    input  logic              ovf_clr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o,
    output logic              overflow_o
);

    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    always_comb begin
        // Status is judged on the registered flags; a pop cannot make room
        // for a push in the same cycle.
        push    = wr_en_i && !full_q && !flush_i;
        pop     = rd_en_i && !empty_q && !flush_i;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        full_d  = (count_d == DepthCnt);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q;
        if (wr_en_i && full_q) ovf_d = 1'b1;
        else if (ovf_clr_i)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            if (push) mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer feeding the UART transmitter.
// Queues bytes from the processor write path and hands them to the UART one at a
// time: a single-cycle uart_write (WRITES) with uart_data (OUT_PORT), issued only
// when tx_rdy (TXRDY) is high, then waits for TXRDY to fall and rise again.
// Ports:
//   clk, reset (synchronous, active-low)
//   wr_en/wr_data - push; flush - drop queued bytes; ovf_clr - clear overflow
//   tx_rdy        - TXRDY level from the transmitter
//   uart_write/uart_data - registered load pulse and byte
//   full, empty, count, overflow - FIFO status
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              ovf_clr,
    input  logic              tx_rdy,
    output logic              uart_write,
    output logic [DATA_W-1:0] uart_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow
);

    tx_state_e         state_q, state_d;
    logic              uart_write_q, uart_write_d;
    logic [DATA_W-1:0] uart_data_q, uart_data_d;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              pop;

    uart_tx_fifo_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (pop),
        .flush_i    (flush),
        .ovf_clr_i  (ovf_clr),
        .rd_data_o  (fifo_rd_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow)
    );

    always_comb begin
        pop         = 1'b0;
        state_d     = state_q;
        uart_data_d = uart_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && tx_rdy && !flush) begin
                    pop         = 1'b1;
                    uart_data_d = fifo_rd_data;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD:      state_d = S_WAIT_BUSY;
            // Falling TXRDY proves the transmitter took the byte.
            S_WAIT_BUSY: if (!tx_rdy) state_d = S_WAIT_RDY;
            S_WAIT_RDY:  if (tx_rdy)  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        uart_write_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            uart_write_q <= 1'b0;
            uart_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            uart_write_q <= uart_write_d;
            uart_data_q  <= uart_data_d;
        end
    end

    assign uart_write = uart_write_q;
    assign uart_data  = uart_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx_rdy = 1'b0;
    logic       uart_write;
    logic [7:0] uart_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    uart_tx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .tx_rdy     (tx_rdy),
        .uart_write (uart_write),
        .uart_data  (uart_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of pending bytes plus hand-off phase
    // (0 idle, 1 load pulse, 2 waiting for TXRDY low, 3 waiting for TXRDY high).
    logic [7:0] q[$];
    bit         m_ovf = 0;
    int         m_phase = 0;
    logic [7:0] m_data = 8'h00;

    logic [7:0] loads[$];
    bit         tx_auto = 0;
    bit         drop_pending = 0;
    int         tx_timer = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop;
        bit was_full;
        if (!reset) begin
            q.delete();
            m_ovf = 0;
            m_phase = 0;
            m_data = 8'h00;
            return;
        end
        was_full = (q.size() == DEPTH);
        pop = (m_phase == 0) && (q.size() != 0) && tx_rdy && !flush;
        if (wr_en && was_full) m_ovf = 1;
        else if (ovf_clr)      m_ovf = 0;
        if (flush) q.delete();
        else begin
            if (pop) m_data = q.pop_front();
            if (wr_en && !was_full) q.push_back(wr_data);
        end
        case (m_phase)
            0:       m_phase = pop ? 1 : 0;
            1:       m_phase = 2;
            2:       m_phase = tx_rdy ? 2 : 3;
            default: m_phase = tx_rdy ? 0 : 3;
        endcase
    endtask

    task automatic compare_all();
        check_eq("uart_write", uart_write, (m_phase == 1));
        check_eq("uart_data", uart_data, m_data);
        check_eq("count", count, q.size());
        check_eq("full", full, (q.size() == DEPTH));
        check_eq("empty", empty, (q.size() == 0));
        check_eq("overflow", overflow, m_ovf);
    endtask

    // One clock: advance model at the edge, compare 1 time unit later, then
    // update the transmitter model that drives tx_rdy for the next cycle.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (uart_write) loads.push_back(uart_data);
        if (tx_auto) begin
            if (m_phase == 1) drop_pending = 1;
            else if (drop_pending) begin
                drop_pending = 0;
                tx_rdy = 1'b0;
                tx_timer = 20;
            end else if (tx_timer > 0) begin
                tx_timer--;
                if (tx_timer == 0) tx_rdy = 1'b1;
            end
        end
    endtask

    task automatic push_bytes(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = first + 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain_expect(input int n, input logic [7:0] first, input string tag);
        int budget;
        loads.delete();
        tx_auto = 1;
        tx_rdy = 1'b1;
        budget = 40 * n + 50;
        while (loads.size() < n && budget > 0) begin
            step();
            budget--;
        end
        check_eq({tag, "_nloads"}, loads.size(), n);
        for (int i = 0; i < loads.size() && i < n; i++)
            check_eq({tag, "_order"}, loads[i], first + 8'(i));
        // Let the transmitter model settle back to idle.
        budget = 60;
        while ((m_phase != 0 || tx_timer != 0 || drop_pending) && budget > 0) begin
            step();
            budget--;
        end
        check_eq({tag, "_settle"}, (budget > 0), 1);
        tx_auto = 0;
    endtask

    initial begin
        int lat;
        int n;

        // Reset for two cycles.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);

        // Single byte, first-byte latency.
        tx_rdy = 1'b1;
        loads.delete();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        lat = 1;
        while (!uart_write && lat < 10) begin
            step();
            lat++;
        end
        check_eq("first_lat", lat, 2);
        check_eq("first_data", uart_data, 8'hA5);
        tx_rdy = 1'b0;
        repeat (10) step();
        tx_rdy = 1'b1;
        repeat (10) step();
        check_eq("single_nloads", loads.size(), 1);

        // Fill to full, overflow, ovf_clr collision, then drain in order.
        tx_rdy = 1'b0;
        push_bytes(16, 8'h01);
        check_eq("full16", count, 16);
        push_bytes(1, 8'hFF);
        check_eq("ovf_set", overflow, 1);
        wr_en = 1'b1;
        wr_data = 8'hFF;
        ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        check_eq("ovf_set_wins", overflow, 1);
        step();
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", overflow, 0);
        drain_expect(16, 8'h01, "fill");

        // Pointer wrap.
        tx_rdy = 1'b0;
        push_bytes(10, 8'h20);
        drain_expect(10, 8'h20, "wrap10");
        tx_rdy = 1'b0;
        push_bytes(12, 8'h40);
        drain_expect(12, 8'h40, "wrap12");
        check_eq("wrap_count", count, 0);

        // Simultaneous push/pop at count 5, then flush during WAIT_BUSY.
        tx_rdy = 1'b0;
        push_bytes(5, 8'h60);
        loads.delete();
        tx_rdy = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h65;
        step();
        wr_en = 1'b0;
        check_eq("pp_count", count, 5);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_count", count, 0);
        tx_rdy = 1'b0;
        repeat (3) step();
        tx_rdy = 1'b1;
        repeat (6) step();
        check_eq("flush_nloads", loads.size(), 1);
        check_eq("flush_data", loads.size() > 0 ? loads[0] : 8'h00, 8'h60);

        // Randomized traffic against the model.
        n = 0;
        repeat (3000) begin
            wr_en   = ($urandom_range(99) < 50);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(99) < 3);
            ovf_clr = ($urandom_range(99) < 5);
            reset   = !($urandom_range(999) < 3);
            if ($urandom_range(99) < 25) tx_rdy = ~tx_rdy;
            step();
            n++;
        end
        reset = 1'b1;
        wr_en = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the Tramelblaze write path, queues them, and hands them one at a time to the UART transmitter. Each hand-off is a single-cycle WRITES/OUT_PORT load, issued only when the transmitter reports TXRDY. This lets firmware burst up to DEPTH bytes without polling TXRDY per byte.

Parameters:
DATA_W, 8, byte width (matches OUT_PORT)
DEPTH, 16, FIFO entries; must be a power of two, at least 2
AW, 4, address width = log2(DEPTH)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
wr_en  in  1  push strobe from processor write decode
wr_data  in  DATA_W  byte to push
flush  in  1  drop all queued bytes
ovf_clr  in  1  clear sticky overflow flag
tx_rdy  in  1  TXRDY level from the UART transmitter
uart_write  out  1  one-cycle load pulse to UART WRITES
uart_data  out  DATA_W  byte to UART OUT_PORT, valid while uart_write=1
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  AW+1  occupancy, 0..DEPTH
overflow  out  1  sticky flag: push attempted while full

Behaviour:
- Reset is sampled on the clk edge with reset==0 and applies to all state. After reset: pointers=0, count=0, empty=1, full=0, overflow=0, uart_write=0, uart_data=0, FSM=IDLE.
- Storage: DEPTH x DATA_W register array. Write pointer and read pointer are AW bits wide and wrap naturally from DEPTH-1 to 0. count is tracked separately.
- Push: accepted when wr_en=1 and full=0 at the start of the cycle. It writes mem[wptr] and increments wptr.
  - wr_en=1 while full=0 → the push is accepted and overflow is unchanged.
  - wr_en=1 while full=1 → the data is dropped, overflow is set to 1, and pointers are unchanged. This holds even if a pop occurs in the same cycle; there is no same-cycle pass-through.
- Pop: performed only by the FSM (IDLE→LOAD transition). It captures mem[rptr] into uart_data and increments rptr.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- count, full and empty are registered and reflect the state after the edge.
- overflow clears only on ovf_clr=1 or on reset. If ovf_clr and a full-push occur in the same cycle, set wins.
- flush=1: wptr=rptr=0 and count=0 on the next edge. A push in the same cycle is ignored. The FSM and the in-flight byte are unaffected, because that byte was already handed to TX. overflow is unaffected.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_RDY.
  - IDLE: if empty=0 and tx_rdy=1 and flush=0 → pop and go to LOAD. Otherwise stay.
  - LOAD: uart_write=1 for exactly this one cycle, with uart_data stable. Next state is WAIT_BUSY.
  - WAIT_BUSY: stay until tx_rdy=0, then go to WAIT_RDY. This guarantees TX has accepted the byte before the next one is loaded.
  - WAIT_RDY: stay until tx_rdy=1, then go to IDLE.
- uart_write is a registered, decoded state output (high only in LOAD). It is never asserted for two consecutive cycles.
- uart_data holds the last popped byte until the next pop.
- Latency: with an empty FIFO, FSM in IDLE and tx_rdy=1:
  - wr_en at cycle N → empty=0 at N+1, pop at edge N+1→N+2, uart_write=1 during cycle N+2. First-byte latency is 2 cycles.
  - Back-to-back bytes are spaced by the TX frame time plus 2 cycles (WAIT_RDY→IDLE→LOAD).
- Reset mid-operation: the FSM returns to IDLE and queued bytes are lost. The UART itself is reset by the same reset.

Decomposition:
- Shared package holds:
  - FSM state encoding: 2-bit localparams S_IDLE=0, S_LOAD=1, S_WAIT_BUSY=2, S_WAIT_RDY=3.
  - DATA_W default.
- One sub-module is natural: sync_fifo (storage, pointers, count, full/empty, overflow, flush).
- uart_tx_fifo wraps sync_fifo together with the hand-off FSM.
- At the UART level, uart_write drives WRITES, uart_data drives OUT_PORT, and TXRDY feeds tx_rdy.

Test Plan:
1. Reset with reset=0 for 2 cycles, then set reset=1 → count=0, empty=1, full=0, overflow=0, uart_write=0.
2. tx_rdy=1, single push of 0xA5 at cycle N → uart_write=1 only in cycle N+2 with uart_data=0xA5, and count returns to 0. Then drop tx_rdy for 10 cycles and raise it → no further uart_write.
3. Push 0x01..0x10 (16 bytes) with tx_rdy=0 → full=1 and count=16. A 17th push of 0xFF → overflow=1 and count stays 16. Then model TX (tx_rdy drops 1 cycle after uart_write and returns 20 cycles later) → 16 loads in order 0x01..0x10, and 0xFF never appears.
4. Wrap-around: with DEPTH=16, push 10, drain 10, push 12, drain 12 → output order preserved across the pointer wrap, and count ends at 0.
5. Simultaneous push and pop with count=5 → count stays 5 and both pointers advance by 1. Asserting flush while a byte is in WAIT_BUSY → count=0 next cycle, the in-flight byte completes, and no further uart_write occurs.
6. Assert ovf_clr in the same cycle as a push while full → overflow remains 1. A subsequent ovf_clr with no conflicting push → overflow=0.
